// File: rtl/soc_loader.sv
// Byte-stream loader: frames carry a header selecting imem/dmem, then big-endian words
// written to the SoC memories; header 0xFF starts the core. Optional LOADER_CHECKSUM_EN.
module soc_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_last,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic                  mem_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  system_ena,
  output logic                  load_err,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_SKIP,
    S_RUN
  } state_e;

  state_e                state_q, state_d;
  logic                  live_q;
  logic                  sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  last_q, last_d;
  logic                  accept;
  logic                  hdr_mem;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            sum_next;
`endif

  assign accept  = rx_valid & rx_ready;
  assign hdr_mem = (rx_data[7:1] == 7'd0);
`ifdef LOADER_CHECKSUM_EN
  assign sum_next = sum_q + rx_data;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // rx_ready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q  <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      live_q  <= 1'b1;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      last_q  <= last_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (hdr_mem)                state_d = rx_last ? S_IDLE : S_LOAD;
          else if (rx_data == 8'hFF)  state_d = rx_last ? S_RUN  : S_SKIP;
          else                        state_d = rx_last ? S_IDLE : S_SKIP;
        end
      end
      S_LOAD: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          if (rx_last)             state_d = S_IDLE;
          else if (cnt_q == 2'd3)  state_d = S_WRITE;
`else
          if (cnt_q == 2'd3)       state_d = S_WRITE;
          else if (rx_last)        state_d = S_IDLE;
`endif
        end
      end
      S_WRITE: state_d = last_q ? S_IDLE : S_LOAD;
      S_SKIP:  if (accept && rx_last) state_d = S_IDLE;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: header latch, byte packing, address advance, error flag
  always_comb begin
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    last_d  = last_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (hdr_mem) begin
            if (!rx_last) begin
              sel_d  = rx_data[0];
              addr_d = '0;
              cnt_d  = '0;
              last_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
              sum_d  = rx_data;
`endif
            end
          end else if (!(rx_data == 8'hFF && rx_last)) begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          if (rx_last) begin
            // Final byte is the checksum: never packed, must close a whole word
            if (cnt_q != 2'd0 || sum_next != 8'h00) err_d = 1'b1;
          end else begin
            sum_d = sum_next;
            cnt_d = cnt_q + 2'd1;
            unique case (cnt_q)
              2'd0: wdata_d[31:24] = rx_data;
              2'd1: wdata_d[23:16] = rx_data;
              2'd2: wdata_d[15:8]  = rx_data;
              default: wdata_d[7:0] = rx_data;
            endcase
          end
`else
          cnt_d = cnt_q + 2'd1;
          unique case (cnt_q)
            2'd0: wdata_d[31:24] = rx_data;
            2'd1: wdata_d[23:16] = rx_data;
            2'd2: wdata_d[15:8]  = rx_data;
            default: wdata_d[7:0] = rx_data;
          endcase
          if (cnt_q == 2'd3)  last_d = rx_last;
          else if (rx_last)   err_d  = 1'b1;
`endif
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == '1) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    rx_ready   = live_q && (state_q == S_IDLE || state_q == S_LOAD || state_q == S_SKIP);
    mem_we     = (state_q == S_WRITE);
    system_ena = (state_q == S_RUN);
    busy       = (state_q == S_LOAD || state_q == S_WRITE || state_q == S_SKIP);
  end

  assign mem_sel   = sel_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_soc_loader.sv
// Scoreboard bench for soc_loader: a frame-level model predicts writes and flags,
// a negedge monitor checks every mem_we pulse against the expected queue.
module tb_soc_loader;
  localparam int unsigned AW = 10;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk, reset, rx_valid, rx_last;
  logic [7:0]    rx_data;
  logic          rx_ready, mem_we, mem_sel, system_ena, load_err, busy;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  soc_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .system_ena(system_ena), .load_err(load_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wr_t           exp_q[$];
  int unsigned   we_cyc[$];
  int unsigned   n_cmp = 0, n_bad = 0, cyc = 0;
  bit            m_err, m_run, m_sel;
  logic [AW-1:0] m_addr;

  always @(posedge clk) cyc++;

  // Monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we !== 1'b0) begin
      wr_t e;
      n_cmp++;
      we_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write got sel=%0d addr=%0h data=%08h want no write",
                 mem_sel, mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_sel, mem_addr, mem_wdata} !== e) begin
          n_bad++;
          $display("FAIL write got sel=%0d addr=%0h data=%08h want sel=%0d addr=%0h data=%08h",
                   mem_sel, mem_addr, mem_wdata, e.sel, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  // Reference model: whole frame in, expected writes and flags out
  task automatic model_frame(input bq_t f);
    int unsigned n, ndata;
    logic [7:0] h;
    n = f.size();
    h = f[0];
    if (h == 8'h00 || h == 8'h01) begin
      if (n == 1) return;
      ndata = n - 1;
`ifdef LOADER_CHECKSUM_EN
      begin
        int unsigned s = 0;
        ndata = n - 2;
        foreach (f[i]) s += f[i];
        if (s % 256 != 0) m_err = 1;
      end
`endif
      m_sel  = h[0];
      m_addr = '0;
      for (int unsigned i = 0; i + 4 <= ndata; i += 4) begin
        exp_q.push_back('{sel: h[0], addr: m_addr, data: {f[i+1], f[i+2], f[i+3], f[i+4]}});
        if (m_addr == '1) m_err = 1;
        m_addr = m_addr + 1'b1;
      end
      if (ndata % 4 != 0) m_err = 1;
    end else if (h == 8'hFF && n == 1) begin
      m_run = 1;
    end else begin
      m_err = 1;
    end
  endtask

  function automatic bq_t with_cks(input bq_t f);
    bq_t r = f;
`ifdef LOADER_CHECKSUM_EN
    int unsigned s = 0;
    foreach (f[i]) s += f[i];
    r.push_back(8'((256 - (s % 256)) % 256));
`endif
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the byte transfers
  task automatic send_byte(input logic [7:0] b, input bit last);
    int unsigned n = 0;
    rx_valid = 1'b1; rx_data = b; rx_last = last;
    forever begin
      @(negedge clk);
      if (rx_ready === 1'b1) break;
      n++;
      if (n > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL handshake_timeout got rx_ready=%0b want 1", rx_ready);
        rx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_last = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input bit gaps);
    model_frame(f);
    foreach (f[i]) begin
      send_byte(f[i], i == f.size() - 1);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic end_check(input string nm);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_pending"}, exp_q.size(), 0);
    check({nm, "_load_err"}, load_err, m_err);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_rx_ready"}, rx_ready, !m_run);
    check({nm, "_system_ena"}, system_ena, m_run);
    check({nm, "_mem_addr"}, mem_addr, m_addr);
    check({nm, "_mem_sel"}, mem_sel, m_sel);
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_sel", mem_sel, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_system_ena", system_ena, 0);
    check("rst_load_err", load_err, 0);
    check("rst_busy", busy, 0);
    exp_q.delete();
    m_err = 0; m_run = 0; m_sel = 0; m_addr = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("rel_rx_ready_before_edge", rx_ready, 0);
    @(posedge clk); #1;
    check("rel_rx_ready_after_edge", rx_ready, 1);
  endtask

  initial begin
    bq_t f;
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_last = 1'b0;
    #1;
    apply_reset();

    send_frame(with_cks('{8'h00, 8'h12, 8'h34, 8'h56, 8'h78}), 0);
    end_check("single_word");

    apply_reset();
    we_cyc.delete();
    send_frame(with_cks('{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h5A, 8'hC3, 8'h3C}), 0);
    end_check("two_words");
    check("two_words_pulses", we_cyc.size(), 2);
    if (we_cyc.size() == 2) check("two_words_spacing", we_cyc[1] - we_cyc[0], 5);

    apply_reset();
    send_frame('{8'h00, 8'hAA, 8'hBB}, 0);
    end_check("partial_word");
    send_frame(with_cks('{8'h00, 8'h11, 8'h22, 8'h33, 8'h44}), 1);
    end_check("after_partial");

    apply_reset();
    send_frame('{8'h7E, 8'h01, 8'h02}, 0);
    end_check("bad_header");
    send_frame('{8'hFF}, 0);
    end_check("run");
    rx_valid = 1'b1; rx_data = 8'h00; rx_last = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("run_hold_rx_ready", rx_ready, 0);
    check("run_hold_system_ena", system_ena, 1);

    apply_reset();
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    apply_reset();
    end_check("reset_midframe");

`ifdef LOADER_CHECKSUM_EN
    apply_reset();
    send_frame('{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6}, 0);
    end_check("cks_good");
    apply_reset();
    send_frame('{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF7}, 0);
    end_check("cks_bad");
`endif

    apply_reset();
    f = '{8'h00};
    for (int i = 0; i < 1025 * 4; i++) f.push_back(8'($urandom));
    send_frame(with_cks(f), 0);
    end_check("wrap");

    for (int k = 0; k < 40; k++) begin
      int unsigned r = $urandom_range(0, 9);
      logic [7:0] h;
      if ($urandom_range(0, 2) == 0) apply_reset();
      h = (r < 4) ? 8'h00 : (r < 8) ? 8'h01 : 8'($urandom);
      if (h == 8'hFF) h = 8'h7E;
      f = '{h};
      repeat ($urandom_range(0, 13)) f.push_back(8'($urandom));
      if ($urandom_range(0, 3) != 0) f = with_cks(f);
      send_frame(f, 1'($urandom_range(0, 1)));
      end_check("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/soc_loader.md
SOC_LOADER -- requirements
Module: soc_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width of the memory write port.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rx_valid  input  1  byte on rx_data is valid.
REQ-005 rx_data  input  8  stream byte.
REQ-006 rx_last  input  1  qualifies the current byte as the final byte of a frame.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 mem_we  output  1  one-cycle word write strobe.
REQ-009 mem_sel  output  1  write target: 0 = instruction memory, 1 = data memory.
REQ-010 mem_addr  output  ADDR_WIDTH  word address of the write.
REQ-011 mem_wdata  output  32  write word.
REQ-012 system_ena  output  1  core run enable, driven to the SoC system_ena input.
REQ-013 load_err  output  1  sticky error flag.
REQ-014 busy  output  1  high whenever the state is not IDLE or RUN.

Function
REQ-015 A byte transfers only on a clock edge where rx_valid and rx_ready are both 1.
REQ-016 States: IDLE, LOAD, WRITE, SKIP, RUN.
REQ-017 IDLE: rx_ready=1; first byte of a frame is the header; 0x00 or 0x01 -> latch mem_sel=header[0], clear mem_addr and byte count, go to LOAD.
REQ-018 IDLE, header 0xFF with rx_last=1 -> RUN; header 0xFF with rx_last=0 -> set load_err, go to SKIP.
REQ-019 IDLE, any other header -> set load_err; go to SKIP if rx_last=0, stay in IDLE if rx_last=1.
REQ-020 IDLE, header 0x00/0x01 with rx_last=1 (empty frame) -> no write, stay in IDLE.
REQ-021 LOAD: rx_ready=1; bytes pack big-endian (first byte -> mem_wdata[31:24]); the 4th byte moves to WRITE.
REQ-022 WRITE: lasts exactly one cycle; mem_we=1, rx_ready=0; the next cycle mem_addr increments by 1; return to LOAD, or to IDLE if the 4th byte carried rx_last.
REQ-023 mem_addr wraps from 2^ADDR_WIDTH-1 to 0; the write that causes the wrap sets load_err; loading continues.
REQ-024 rx_last on byte 1-3 of a word: partial word discarded, no write, load_err set, -> IDLE.
REQ-025 SKIP: rx_ready=1; bytes discarded; rx_last -> IDLE.
REQ-026 RUN: system_ena=1, rx_ready=0; held until reset; no further bytes are accepted.
REQ-027 Throughput: max one word per 5 cycles (4 bytes + 1 WRITE cycle).
REQ-028 mem_addr, mem_sel and mem_wdata stay stable while mem_we=1.

Reset
REQ-029 reset=0 asynchronously forces IDLE, rx_ready=0 while asserted and 1 from the first edge after release, and mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, system_ena=0, load_err=0, busy=0.
REQ-030 Reset mid-frame drops the partial word; no write is issued.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN defined: the final byte of every 0x00/0x01 frame is a checksum and is not packed; the mod-256 sum of all frame bytes including the header and the checksum must equal 0x00, else load_err is set at frame end.
REQ-032 With LOADER_CHECKSUM_EN defined, the word-alignment rule of REQ-024 applies to the bytes preceding the checksum byte.
REQ-033 Macro undefined: no checksum byte; the final byte is data.

Verification
REQ-034 Frame 00,12,34,56,78(last) -> one mem_we, mem_sel=0, mem_addr=0, mem_wdata=0x12345678, load_err=0, back to IDLE.
REQ-035 Frame 01 then 8 data bytes, last on byte 8 -> writes to dmem at addr 0 and 1, two mem_we pulses 5 cycles apart at full rate.
REQ-036 Frame 00,AA,BB(last) -> no mem_we, load_err=1, IDLE; next valid frame still writes.
REQ-037 Header 0x7E, two bytes, last -> SKIP, no writes, load_err=1; then FF(last) -> system_ena=1, rx_ready=0.
REQ-038 Reset asserted after 2 data bytes -> all outputs at reset values immediately, no write; a 1025-word imem load with ADDR_WIDTH=10 wraps to addr 0 and sets load_err.
REQ-039 LOADER_CHECKSUM_EN: 00,01,02,03,04,F6(last) -> one write 0x01020304, load_err=0; checksum byte F7 -> load_err=1.
